id_ex_stage_reg: RTL

Pipeline register between the instruction-decode stage and the execute stage of the ARM-subset core. It captures decoded control bits, register-file operands, immediates, PC, destination index and status flags at each rising clock edge and presents them to EX. It supports a global stall (hold), a branch flush, and a hazard bubble, and carries a valid bit so downstream stages and the bench can tell real instructions from bubbles.

---
 rtl/id_ex_stage_reg.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall hold, flush kill and hazard bubble.
// Optional define FORWARDING_EN builds the source-index registers.
module id_ex_stage_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        bubble,
    input  logic        id_valid,
    input  logic        id_wb_en,
    input  logic        id_mem_r_en,
    input  logic        id_mem_w_en,
    input  logic        id_b,
    input  logic        id_s,
    input  logic [3:0]  id_exe_cmd,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_val_rn,
    input  logic [31:0] id_val_rm,
    input  logic        id_imm,
    input  logic [11:0] id_shift_operand,
    input  logic [23:0] id_signed_imm_24,
    input  logic [3:0]  id_dest,
    input  logic [3:0]  id_sr,
    input  logic [3:0]  id_src_1,
    input  logic [3:0]  id_src_2,
    input  logic        id_two_src,
    output logic        ex_valid,
    output logic        ex_wb_en,
    output logic        ex_mem_r_en,
    output logic        ex_mem_w_en,
    output logic        ex_b,
    output logic        ex_s,
    output logic [3:0]  ex_exe_cmd,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_val_rn,
    output logic [31:0] ex_val_rm,
    output logic        ex_imm,
    output logic [11:0] ex_shift_operand,
    output logic [23:0] ex_signed_imm_24,
    output logic [3:0]  ex_dest,
    output logic [3:0]  ex_sr,
    output logic [3:0]  ex_src_1,
    output logic [3:0]  ex_src_2,
    output logic        ex_two_src
);

    logic        r_valid;
    logic        r_wb_en;
    logic        r_mem_r_en;
    logic        r_mem_w_en;
    logic        r_b;
    logic        r_s;
    logic [3:0]  r_exe_cmd;
    logic [31:0] r_pc;
    logic [31:0] r_val_rn;
    logic [31:0] r_val_rm;
    logic        r_imm;
    logic [11:0] r_shift_operand;
    logic [23:0] r_signed_imm_24;
    logic [3:0]  r_dest;
    logic [3:0]  r_sr;

    logic w_kill_ctrl;
    logic w_kill_data;

    // Control is dropped for flush, bubble or a non-instruction in ID.
    assign w_kill_ctrl = flush | bubble | ~id_valid;
    assign w_kill_data = flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_b        <= 1'b0;
            r_s        <= 1'b0;
            r_exe_cmd  <= 4'b0000;
        end else if (!stall) begin
            r_valid    <= id_valid & ~flush & ~bubble;
            r_wb_en    <= id_wb_en & ~w_kill_ctrl;
            r_mem_r_en <= id_mem_r_en & ~w_kill_ctrl;
            r_mem_w_en <= id_mem_w_en & ~w_kill_ctrl;
            r_b        <= id_b & ~w_kill_ctrl;
            r_s        <= id_s & ~w_kill_ctrl;
            r_exe_cmd  <= w_kill_ctrl ? 4'b0000 : id_exe_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc            <= 32'd0;
            r_val_rn        <= 32'd0;
            r_val_rm        <= 32'd0;
            r_imm           <= 1'b0;
            r_shift_operand <= 12'd0;
            r_signed_imm_24 <= 24'd0;
            r_dest          <= 4'd0;
            r_sr            <= 4'd0;
        end else if (!stall) begin
            if (w_kill_data) begin
                r_pc            <= 32'd0;
                r_val_rn        <= 32'd0;
                r_val_rm        <= 32'd0;
                r_imm           <= 1'b0;
                r_shift_operand <= 12'd0;
                r_signed_imm_24 <= 24'd0;
                r_dest          <= 4'd0;
                r_sr            <= 4'd0;
            end else begin
                r_pc            <= id_pc;
                r_val_rn        <= id_val_rn;
                r_val_rm        <= id_val_rm;
                r_imm           <= id_imm;
                r_shift_operand <= id_shift_operand;
                r_signed_imm_24 <= id_signed_imm_24;
                r_dest          <= id_dest;
                r_sr            <= id_sr;
            end
        end
    end

`ifdef FORWARDING_EN
    logic [3:0] r_src_1;
    logic [3:0] r_src_2;
    logic       r_two_src;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_src_1   <= 4'd0;
            r_src_2   <= 4'd0;
            r_two_src <= 1'b0;
        end else if (!stall) begin
            r_src_1   <= w_kill_data ? 4'd0 : id_src_1;
            r_src_2   <= w_kill_data ? 4'd0 : id_src_2;
            r_two_src <= w_kill_data ? 1'b0 : id_two_src;
        end
    end

    assign ex_src_1   = r_src_1;
    assign ex_src_2   = r_src_2;
    assign ex_two_src = r_two_src;
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{id_src_1, id_src_2, id_two_src};
    assign ex_src_1     = 4'd0;
    assign ex_src_2     = 4'd0;
    assign ex_two_src   = 1'b0;
`endif

    assign ex_valid         = r_valid;
    assign ex_wb_en         = r_wb_en;
    assign ex_mem_r_en      = r_mem_r_en;
    assign ex_mem_w_en      = r_mem_w_en;
    assign ex_b             = r_b;
    assign ex_s             = r_s;
    assign ex_exe_cmd       = r_exe_cmd;
    assign ex_pc            = r_pc;
    assign ex_val_rn        = r_val_rn;
    assign ex_val_rm        = r_val_rm;
    assign ex_imm           = r_imm;
    assign ex_shift_operand = r_shift_operand;
    assign ex_signed_imm_24 = r_signed_imm_24;
    assign ex_dest          = r_dest;
    assign ex_sr            = r_sr;

endmodule
